// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: one-outstanding memory requester feeding a small prefetch FIFO toward decode.
// Define FETCH_BYPASS_EN to forward a returning word straight to decode when the queue is empty.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef NOP
`define NOP 16'hB000
`endif
`ifndef ALU_OP
`define ALU_OP 4'hF
`endif
`ifndef FUNC_HLT
`define FUNC_HLT 6'd29
`endif

module instr_fetch_queue #(
    parameter int                     QUEUE_DEPTH = 4,
    parameter logic [`WORD_SIZE-1:0]  RESET_PC    = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  i_readM,
    output logic [`WORD_SIZE-1:0] i_address,
    input  logic                  i_ready,
    input  logic [`WORD_SIZE-1:0] i_data,
    input  logic                  i_data_valid,
    output logic [`WORD_SIZE-1:0] instr_out,
    output logic [`WORD_SIZE-1:0] pc_out,
    output logic                  instr_valid,
    input  logic                  decode_stall,
    input  logic                  redirect,
    input  logic [`WORD_SIZE-1:0] redirect_pc,
    output logic                  halted
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {FETCH, WAIT, STOP, HALTED} state_t;
    state_t state, state_nxt;

    logic [`WORD_SIZE-1:0] fetch_pc, req_pc;
    logic                  outstanding, squash, halted_r;
    logic [`WORD_SIZE-1:0] q_instr [QUEUE_DEPTH];
    logic [`WORD_SIZE-1:0] q_pc    [QUEUE_DEPTH];
    logic [AW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         count;

    logic resp, keep, q_valid, byp, push, pop, consumed, redir, space, handshake;

    function automatic logic is_hlt(input logic [`WORD_SIZE-1:0] w);
        return (w[15:12] == `ALU_OP) && (w[5:0] == `FUNC_HLT);
    endfunction

    // Responses are only meaningful while a request is in flight; anything else is stale.
    assign resp      = i_data_valid & outstanding;
    assign keep      = resp & ~squash;
    assign q_valid   = (count != '0);
    assign redir     = redirect & (state != HALTED);
    assign space     = ({1'b0, count} + {{CW{1'b0}}, outstanding}) < (CW+1)'(QUEUE_DEPTH);
    assign i_readM   = ~reset & (state == FETCH) & ~outstanding & ~redirect & space;
    assign i_address = fetch_pc;
    assign handshake = i_readM & i_ready;
    assign halted    = halted_r;

`ifdef FETCH_BYPASS_EN
    assign byp         = keep & ~q_valid & ~decode_stall;
    assign instr_valid = q_valid | byp;
    assign instr_out   = q_valid ? q_instr[rd_ptr] : (byp ? i_data : `NOP);
    assign pc_out      = q_valid ? q_pc[rd_ptr]    : (byp ? req_pc : '0);
`else
    assign byp         = 1'b0;
    assign instr_valid = q_valid;
    assign instr_out   = q_valid ? q_instr[rd_ptr] : `NOP;
    assign pc_out      = q_valid ? q_pc[rd_ptr]    : '0;
`endif

    assign push     = keep & ~byp & ~redir;
    assign pop      = q_valid & ~decode_stall & ~redir;
    assign consumed = instr_valid & ~decode_stall;

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (handshake) state_nxt = WAIT;
            WAIT:    if (keep) state_nxt = is_hlt(i_data) ? STOP : FETCH;
            default: state_nxt = state;
        endcase
        if (consumed && is_hlt(instr_out) && state != HALTED) state_nxt = HALTED;
        if (redir) state_nxt = FETCH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            req_pc      <= RESET_PC;
            outstanding <= 1'b0;
            squash      <= 1'b0;
            halted_r    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == HALTED) halted_r <= 1'b1;
            if (handshake) begin
                fetch_pc    <= fetch_pc + 16'd1;
                req_pc      <= fetch_pc;
                outstanding <= 1'b1;
            end
            if (resp) begin
                outstanding <= 1'b0;
                squash      <= 1'b0;
            end
            if (redir) begin
                fetch_pc <= redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                // The in-flight reply still has to drain before refetching.
                if (outstanding && !resp) squash <= 1'b1;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= i_data;
            q_pc[wr_ptr]    <= req_pc;
        end
    end
endmodule
